// File: rtl/nec_ir_decoder.sv
// NEC infrared remote decoder: times marks and spaces in microsecond ticks,
// validates 32-bit frames and repeat codes, and drives a held SNES button mask.
module nec_ir_decoder #(
  parameter int         CLK_PER_US = 1,
  parameter int         HOLD_MS    = 110,
  parameter logic [7:0] IR_ADDR    = 8'h00
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ir_in,
  output logic [31:0] ir_data,
  output logic        ir_valid,
  output logic [7:0]  ir_mux,
  output logic        ir_err
);

  localparam int HOLD_LIM = HOLD_MS * 1000;
  localparam int HW       = $clog2(HOLD_LIM + 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    REP_STOP
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          ir_d;
  logic [5:0]    presc;
  logic [13:0]   pulse_cnt;
  logic [HW-1:0] hold_cnt;
  logic [31:0]   shreg;
  logic [4:0]    bit_idx;

  logic ir_s, fall, rise, tick;
  logic is_mark, is_space, timeout;
  logic short_ok, long_ok, frame_ok;

  function automatic logic in_rng(input logic [13:0] v, input logic [13:0] lo,
                                  input logic [13:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic [7:0] cmd_to_mask(input logic [7:0] cmd);
    case (cmd)
      8'h1C:   return 8'h01;
      8'h45:   return 8'h02;
      8'h46:   return 8'h04;
      8'h47:   return 8'h08;
      8'h18:   return 8'h10;
      8'h52:   return 8'h20;
      8'h08:   return 8'h40;
      8'h5A:   return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  assign ir_s     = sync[1];
  assign fall     = ir_d & ~ir_s;
  assign rise     = ~ir_d & ir_s;
  assign tick     = (presc == 6'(CLK_PER_US - 1));

  assign is_mark  = (state == LEAD_MARK) || (state == BIT_MARK) ||
                    (state == STOP_MARK) || (state == REP_STOP);
  assign is_space = (state == LEAD_SPACE) || (state == BIT_SPACE);
  assign timeout  = (is_mark && pulse_cnt >= 14'd10001) ||
                    (is_space && pulse_cnt >= 14'd5001);

  // 560 us nominal bit/stop mark or zero-bit space; 1690 us nominal one-bit space.
  assign short_ok = in_rng(pulse_cnt, 14'd400, 14'd700);
  assign long_ok  = in_rng(pulse_cnt, 14'd1400, 14'd1900);

  assign frame_ok = (shreg[7:0] == ~shreg[15:8]) &&
                    (shreg[23:16] == ~shreg[31:24]) &&
                    (shreg[7:0] == IR_ADDR);

  // Front end: synchronizer, edge history, us prescaler and pulse-width counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the synchronizer resets to the idle-high line level so that
      // leaving reset never fabricates a falling edge.
      sync      <= 2'b11;
      ir_d      <= 1'b1;
      presc     <= '0;
      pulse_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample the
      // pre-edge value of the others, which is what forms a proper shift chain.
      sync  <= {sync[0], ir_in};
      ir_d  <= ir_s;
      presc <= tick ? '0 : presc + 1'b1;
      if (fall || rise)
        pulse_cnt <= '0;
      else if (tick && pulse_cnt != 14'h3FFF)
        pulse_cnt <= pulse_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      ir_data  <= '0;
      ir_valid <= 1'b0;
      ir_err   <= 1'b0;
      ir_mux   <= '0;
      hold_cnt <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
    end else begin
      ir_valid <= 1'b0;
      ir_err   <= 1'b0;

      // NOTE: within one always_ff the last non-blocking assignment wins, so a
      // hold restart further down overrides the expiry clear on the same cycle.
      if (hold_cnt == HW'(HOLD_LIM))
        ir_mux <= 8'h00;
      else if (tick)
        hold_cnt <= hold_cnt + 1'b1;

      if (timeout) begin
        state  <= IDLE;
        ir_err <= 1'b1;
      end else begin
        case (state)
          IDLE: if (fall) state <= LEAD_MARK;

          LEAD_MARK: if (rise) begin
            if (in_rng(pulse_cnt, 14'd8000, 14'd10000)) begin
              state <= LEAD_SPACE;
            end else begin
              state  <= IDLE;
              ir_err <= 1'b1;
            end
          end

          LEAD_SPACE: if (fall) begin
            if (in_rng(pulse_cnt, 14'd4000, 14'd5000)) begin
              state   <= BIT_MARK;
              bit_idx <= '0;
            end else if (in_rng(pulse_cnt, 14'd1800, 14'd2700)) begin
              state <= REP_STOP;
            end else begin
              state  <= IDLE;
              ir_err <= 1'b1;
            end
          end

          BIT_MARK: if (rise) begin
            if (short_ok) begin
              state <= BIT_SPACE;
            end else begin
              state  <= IDLE;
              ir_err <= 1'b1;
            end
          end

          BIT_SPACE: if (fall) begin
            if (short_ok || long_ok) begin
              shreg[bit_idx] <= long_ok;
              if (bit_idx == 5'd31) begin
                state <= STOP_MARK;
              end else begin
                bit_idx <= bit_idx + 1'b1;
                state   <= BIT_MARK;
              end
            end else begin
              state  <= IDLE;
              ir_err <= 1'b1;
            end
          end

          STOP_MARK: if (rise) begin
            state <= IDLE;
            if (short_ok && frame_ok) begin
              ir_data  <= shreg;
              ir_valid <= 1'b1;
              ir_mux   <= cmd_to_mask(shreg[23:16]);
              hold_cnt <= '0;
            end else begin
              ir_err <= 1'b1;
            end
          end

          REP_STOP: if (rise) begin
            state <= IDLE;
            if (!short_ok) begin
              ir_err <= 1'b1;
            end else if (ir_mux != 8'h00) begin
              hold_cnt <= '0;
              ir_mux   <= ir_mux;
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Self-checking bench for nec_ir_decoder: randomized NEC frames and repeat codes
// compared against a frame-level model of acceptance, mask lookup and hold time.
module tb_nec_ir_decoder;

  localparam int HOLD_CYC = 110 * 1000;  // 1 clk per us at default CLK_PER_US

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ir_in = 1'b1;
  logic [31:0] ir_data;
  logic        ir_valid;
  logic [7:0]  ir_mux;
  logic        ir_err;

  nec_ir_decoder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ir_in    (ir_in),
    .ir_data  (ir_data),
    .ir_valid (ir_valid),
    .ir_mux   (ir_mux),
    .ir_err   (ir_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse monitor
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;
  int last_err_cyc = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ir_valid) n_valid++;
    if (ir_err) begin
      n_err++;
      last_err_cyc = cyc;
    end
    if (ir_valid && ir_err) n_both++;
  end

  // Reference model: accepted frame, its button mask and when that mask expires.
  logic [7:0]  codes [8] = '{8'h1C, 8'h45, 8'h46, 8'h47, 8'h18, 8'h52, 8'h08, 8'h5A};
  logic [31:0] exp_data = '0;
  logic [7:0]  exp_mask = '0;
  int          mux_deadline = 0;

  function automatic logic [31:0] make_frame(input logic [7:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

  function automatic logic [7:0] mask_of(input logic [7:0] cmd);
    logic [7:0] m = 8'h00;
    for (int i = 0; i < 8; i++) if (codes[i] == cmd) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [7:0] exp_mux_now();
    return (cyc < mux_deadline) ? exp_mask : 8'h00;
  endfunction

  task automatic model_frame(input logic [31:0] f);
    if (f[7:0] == ~f[15:8] && f[23:16] == ~f[31:24] && f[7:0] == 8'h00) begin
      exp_data     = f;
      exp_mask     = mask_of(f[23:16]);
      mux_deadline = cyc + HOLD_CYC;
    end
  endtask

  task automatic model_repeat();
    if (exp_mux_now() != 8'h00) mux_deadline = cyc + HOLD_CYC;
  endtask

  // Line drivers (changes happen on the falling clock edge)
  task automatic low(input int n);
    ir_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic high(input int n);
    ir_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_head();
    low(9000);
    high(4500);
  endtask

  task automatic send_bits(input logic [31:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      low(560);
      high(f[i] ? 1690 : 560);
    end
  endtask

  task automatic send_stop();
    low(560);
    ir_in = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] f);
    send_head();
    send_bits(f, 0, 31);
    send_stop();
  endtask

  // Tests
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ir_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", ir_data); end
    checks++; if (ir_mux !== 8'h0) begin errors++; $display("FAIL reset_mux: got %h want 0", ir_mux); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ir_valid); end
    checks++; if (ir_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ir_err); end
    reset_n = 1'b1;
    high(100);
  endtask

  task automatic test_nominal();
    int v0 = n_valid;
    int e0 = n_err;
    logic [31:0] f = 32'hE718FF00;
    send_frame(f);
    model_frame(f);
    high(20);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL nominal_valid_pulses: got %0d want 1", n_valid - v0); end
    checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL nominal_err_pulses: got %0d want 0", n_err - e0); end
    checks++; if (ir_data !== exp_data) begin errors++; $display("FAIL nominal_data: got %h want %h", ir_data, exp_data); end
    checks++; if (ir_mux !== exp_mux_now()) begin errors++; $display("FAIL nominal_mux: got %h want %h", ir_mux, exp_mux_now()); end
  endtask

  task automatic test_corrupt();
    int v0 = n_valid;
    int e0 = n_err;
    logic [31:0] f = 32'h0018FF00;
    high($urandom_range(500, 3000));
    send_frame(f);
    model_frame(f);
    high(20);
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL corrupt_valid_pulses: got %0d want 0", n_valid - v0); end
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL corrupt_err_pulses: got %0d want 1", n_err - e0); end
    checks++; if (ir_data !== exp_data) begin errors++; $display("FAIL corrupt_data: got %h want %h", ir_data, exp_data); end
    checks++; if (ir_mux !== exp_mux_now()) begin errors++; $display("FAIL corrupt_mux: got %h want %h", ir_mux, exp_mux_now()); end
  endtask

  task automatic test_repeat();
    int v0, e0, t0, t_rep;
    logic [31:0] f;
    high($urandom_range(500, 3000));
    f  = make_frame(8'h00, codes[$urandom_range(0, 7)]);
    v0 = n_valid;
    e0 = n_err;
    t0 = cyc;
    send_frame(f);
    model_frame(f);
    high(20);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL repeat_frame_valid: got %0d want 1", n_valid - v0); end
    checks++; if (ir_mux !== exp_mux_now()) begin errors++; $display("FAIL repeat_frame_mux: got %h want %h", ir_mux, exp_mux_now()); end
    // Repeat code 108 ms after the frame start
    while (cyc < t0 + 108000) @(negedge clk);
    low(9000);
    high(2250);
    send_stop();
    model_repeat();
    t_rep = cyc;
    high(20);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL repeat_no_valid: got %0d pulses want 1", n_valid - v0); end
    checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL repeat_no_err: got %0d pulses want 0", n_err - e0); end
    while (cyc < t_rep + HOLD_CYC - 100) @(negedge clk);
    checks++; if (ir_mux !== exp_mux_now()) begin errors++; $display("FAIL repeat_hold_kept: got %h want %h", ir_mux, exp_mux_now()); end
    while (cyc < t_rep + HOLD_CYC + 100) @(negedge clk);
    checks++; if (ir_mux !== exp_mux_now()) begin errors++; $display("FAIL repeat_hold_expired: got %h want %h", ir_mux, exp_mux_now()); end
  endtask

  task automatic test_leader_errors();
    int e0 = n_err;
    int v0, t_f, dt;
    logic [31:0] f;
    high(500);
    low(7000);
    checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL short_leader_early_err: got %0d want 0", n_err - e0); end
    high(10);
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL short_leader_err: got %0d want 1", n_err - e0); end
    high(1000);
    t_f = cyc;
    low(12000);
    dt = last_err_cyc - t_f;
    checks++; if (n_err - e0 !== 2) begin errors++; $display("FAIL long_leader_err: got %0d want 2", n_err - e0); end
    checks++; if (dt < 10001 || dt > 10012) begin errors++; $display("FAIL long_leader_err_time: got %0d want 10001..10012", dt); end
    high(1000);
    f  = make_frame(8'h00, 8'($urandom_range(0, 255)));
    v0 = n_valid;
    e0 = n_err;
    send_frame(f);
    model_frame(f);
    high(20);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL after_err_valid: got %0d want 1", n_valid - v0); end
    checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL after_err_err: got %0d want 0", n_err - e0); end
    checks++; if (ir_data !== exp_data) begin errors++; $display("FAIL after_err_data: got %h want %h", ir_data, exp_data); end
    checks++; if (ir_mux !== exp_mux_now()) begin errors++; $display("FAIL after_err_mux: got %h want %h", ir_mux, exp_mux_now()); end
  endtask

  task automatic test_bad_addr();
    int v0 = n_valid;
    int e0 = n_err;
    logic [31:0] f = make_frame(8'h01, 8'h18);
    high($urandom_range(500, 1500));
    send_frame(f);
    model_frame(f);
    high(20);
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL bad_addr_valid: got %0d want 0", n_valid - v0); end
    checks++; if (n_err - e0 !== 1) begin errors++; $display("FAIL bad_addr_err: got %0d want 1", n_err - e0); end
    checks++; if (ir_data !== exp_data) begin errors++; $display("FAIL bad_addr_data: got %h want %h", ir_data, exp_data); end
    checks++; if (ir_mux !== exp_mux_now()) begin errors++; $display("FAIL bad_addr_mux: got %h want %h", ir_mux, exp_mux_now()); end
  endtask

  task automatic test_unmapped_cmd();
    int v0 = n_valid;
    int e0 = n_err;
    logic [31:0] f = make_frame(8'h00, 8'h40);
    high($urandom_range(500, 1500));
    send_frame(f);
    model_frame(f);
    high(20);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL unmapped_valid: got %0d want 1", n_valid - v0); end
    checks++; if (n_err - e0 !== 0) begin errors++; $display("FAIL unmapped_err: got %0d want 0", n_err - e0); end
    checks++; if (ir_data !== exp_data) begin errors++; $display("FAIL unmapped_data: got %h want %h", ir_data, exp_data); end
    checks++; if (ir_mux !== exp_mux_now()) begin errors++; $display("FAIL unmapped_mux: got %h want %h", ir_mux, exp_mux_now()); end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    logic [31:0] f1, f2;
    f1 = make_frame(8'h00, codes[$urandom_range(0, 7)]);
    f2 = make_frame(8'h00, codes[$urandom_range(0, 7)]);
    high(1000);
    send_head();
    send_bits(f1, 0, 14);
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (ir_data !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h want 0", ir_data); end
    checks++; if (ir_mux !== 8'h0) begin errors++; $display("FAIL midreset_mux: got %h want 0", ir_mux); end
    checks++; if (ir_valid !== 1'b0 || ir_err !== 1'b0) begin errors++; $display("FAIL midreset_pulses: got valid %b err %b want 0 0", ir_valid, ir_err); end
    reset_n = 1'b1;
    exp_data     = '0;
    exp_mask     = '0;
    mux_deadline = 0;
    v0 = n_valid;
    send_bits(f1, 15, 31);
    send_stop();
    high(20000);
    checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL midreset_partial_valid: got %0d want 0", n_valid - v0); end
    v0 = n_valid;
    send_frame(f2);
    model_frame(f2);
    high(20);
    checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL midreset_next_valid: got %0d want 1", n_valid - v0); end
    checks++; if (ir_data !== exp_data) begin errors++; $display("FAIL midreset_next_data: got %h want %h", ir_data, exp_data); end
    checks++; if (ir_mux !== exp_mux_now()) begin errors++; $display("FAIL midreset_next_mux: got %h want %h", ir_mux, exp_mux_now()); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_corrupt();
    test_repeat();
    test_leader_errors();
    test_bad_addr();
    test_unmapped_cmd();
    test_reset_mid_frame();
    checks++; if (n_both !== 0) begin errors++; $display("FAIL valid_err_overlap: got %0d cycles want 0", n_both); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish within 2000000 cycles");
    $fatal(1);
  end

endmodule
